host_mem_arbiter: RTL

- Shares the single host memory-controller port (DataOut_host/AddrOut_host/op_host out; DataIn_host/rd_valid_host/tx_done_host in) between NUM_REQ requesters, e.g. the CPU cache controller and the accelerator DMA engine.
- Round-robin, one transaction in flight, held from issue until tx_done_host.
- A watchdog releases a hung transaction.

---
 rtl/host_mem_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/host_mem_arbiter.sv
// host_mem_arbiter
// Round-robin arbiter that shares the host memory-controller port between
// NUM_REQ requesters. Only one transaction is in flight at a time. The winner
// keeps ownership from issue until the controller reports completion. A
// watchdog forces release of a transaction that never completes.
module host_mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_REQ-1:0]   req_op,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [512*NUM_REQ-1:0] req_data,
  output logic [511:0]           req_rd_data,
  output logic [NUM_REQ-1:0]     req_rd_valid,
  output logic [NUM_REQ-1:0]     req_tx_done,
  output logic [NUM_REQ-1:0]     req_timeout,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  input  logic [511:0]           DataIn_host,
  input  logic                   tx_done_host,
  input  logic                   rd_valid_host,
  output logic [511:0]           DataOut_host,
  output logic [31:0]            AddrOut_host,
  output logic [1:0]             op_host
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [31:0]   TO_LAST   = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   NUM_REQ_W = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RELEASE
  } state_t;

  state_t             state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      gnt_idx;
  logic [31:0]        counter;

  logic [NUM_REQ-1:0] req_valid;
  logic               found;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        cand;
  logic               done_hit;
  logic               watchdog_hit;

  // Reserved op 11 and NOP both count as "no request".
  always_comb begin
    req_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid[k] = (req_op[2*k +: 2] == OP_READ) || (req_op[2*k +: 2] == OP_WRITE);
    end
  end

  // Rotating priority scan starting just after the last requester served.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k + 1);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!found && req_valid[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  // Completion wins over the watchdog when both land on the same cycle.
  always_comb begin
    done_hit     = (state == ST_ACTIVE) && tx_done_host;
    watchdog_hit = (state == ST_ACTIVE) && (TIMEOUT_CYCLES != 0) &&
                   (counter == TO_LAST) && !tx_done_host;
  end

  // Host-side strobes are forwarded only to the owner and only while ACTIVE.
  always_comb begin
    req_rd_data  = DataIn_host;
    req_rd_valid = '0;
    req_tx_done  = '0;
    req_timeout  = '0;
    if (state == ST_ACTIVE) begin
      if (rd_valid_host && (op_host == OP_READ)) begin
        req_rd_valid = grant;
      end
      if (done_hit || watchdog_hit) begin
        req_tx_done = grant;
      end
      if (watchdog_hit) begin
        req_timeout = grant;
      end
    end
  end

  assign busy = (state != ST_IDLE);

  // Arbitration FSM. It latches the winner's request into the host registers and
  // clears ownership on the way into the single RELEASE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant        <= '0;
      gnt_idx      <= '0;
      last_grant   <= LAST_IDX;
      op_host      <= OP_NOP;
      AddrOut_host <= '0;
      DataOut_host <= '0;
      counter      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            op_host      <= req_op[2*win_idx +: 2];
            AddrOut_host <= req_addr[32*win_idx +: 32];
            DataOut_host <= req_data[512*win_idx +: 512];
            grant        <= NUM_REQ'(1) << win_idx;
            gnt_idx      <= win_idx;
            counter      <= '0;
            state        <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (done_hit || watchdog_hit) begin
            op_host    <= OP_NOP;
            grant      <= '0;
            counter    <= '0;
            last_grant <= gnt_idx;
            state      <= ST_RELEASE;
          end else begin
            counter <= counter + 32'd1;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
